// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
//   Owns the program counter and the instruction register. During FETCH it
//   requests a word from program memory, stalls the phase sequencer for as
//   long as memory is not ready, then latches the word into IR and advances
//   PC. A taken branch reloads PC on the COMMIT edge.
//
//   Optional feature macro: FETCH_TIMEOUT_EN
//     Defined   -> a 4-bit wait counter aborts a fetch after TIMEOUT wait
//                  cycles. The abort injects a NOP, sets a sticky FETCH_FAULT
//                  flag and leaves PC unchanged.
//     Undefined -> no counter. WAIT lasts until memory answers, and
//                  FETCH_FAULT is tied low.
module instruction_fetch_unit #(
  parameter logic [15:0] RESET_VECTOR = 16'h0000,
  parameter logic [15:0] PC_STEP      = 16'd2,
  parameter logic [3:0]  TIMEOUT      = 4'd15
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        FETCH,
  input  logic        DECODE,
  input  logic        EXECUTE,
  input  logic        COMMIT,
  input  logic [15:0] DATA_IN,
  input  logic        MEM_READY,
  input  logic        PC_LD,
  input  logic [15:0] PC_D,
  output logic [15:0] ADDR,
  output logic        RD_EN,
  output logic        STALL,
  output logic [15:0] INSTRUCTION,
  output logic        IR_VALID,
  output logic [15:0] PC,
  output logic        FETCH_FAULT
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t      state, state_next;
  logic [15:0] pc, pc_next;
  logic [15:0] ir, ir_next;
  logic        ir_valid, ir_valid_next;
  logic        latch;
  logic        timeout_hit;

  // DECODE and EXECUTE are part of the phase bus but need no action here.
  logic unused_phase;
  assign unused_phase = DECODE ^ EXECUTE;

`ifdef FETCH_TIMEOUT_EN
  logic [3:0] wait_cnt, wait_cnt_next;
  logic       fault, fault_next;

  // The abort cycle: still waiting, still fetching, and the limit is reached.
  assign timeout_hit = (state == WAIT) && FETCH && !MEM_READY && (wait_cnt == TIMEOUT);

  // Wait counter: 1 on entering WAIT, saturating count while in WAIT, 0 on leaving.
  always_comb begin
    wait_cnt_next = wait_cnt;
    fault_next    = fault | timeout_hit;
    if (state_next == IDLE) begin
      wait_cnt_next = 4'd0;
    end else if (state == IDLE) begin
      wait_cnt_next = 4'd1;
    end else if (wait_cnt != 4'hF) begin
      wait_cnt_next = wait_cnt + 4'd1;
    end
  end

  // Counter and sticky fault register; only RESET clears the fault.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wait_cnt <= 4'd0;
      fault    <= 1'b0;
    end else begin
      wait_cnt <= wait_cnt_next;
      fault    <= fault_next;
    end
  end

  assign FETCH_FAULT = fault;
`else
  logic [3:0] unused_timeout;
  assign unused_timeout = TIMEOUT;
  assign timeout_hit    = 1'b0;
  assign FETCH_FAULT    = 1'b0;
`endif

  // Next-state, IR/PC update and branch override for the fetch FSM.
  // NOTE: every variable gets a default at the top of the block; a path that
  // left one unassigned would infer a latch instead of combinational logic.
  always_comb begin
    state_next    = state;
    pc_next       = pc;
    ir_next       = ir;
    ir_valid_next = ir_valid;
    latch         = 1'b0;

    // The instruction has been consumed once it is committed.
    if (COMMIT) begin
      ir_valid_next = 1'b0;
    end

    case (state)
      IDLE: begin
        if (FETCH) begin
          if (MEM_READY) begin
            latch = 1'b1;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (!FETCH) begin
          // The sequencer left FETCH mid-wait: abandon the access untouched.
          state_next = IDLE;
        end else if (MEM_READY) begin
          latch      = 1'b1;
          state_next = IDLE;
        end else if (timeout_hit) begin
          // Replace the lost word with a NOP so the decoders see something
          // harmless. PC stays put so software can retry the same address.
          ir_next       = 16'h0000;
          ir_valid_next = 1'b1;
          state_next    = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    if (latch) begin
      ir_next       = DATA_IN;
      ir_valid_next = 1'b1;
      pc_next       = pc + PC_STEP;
    end

    // A taken branch takes precedence over the sequential increment.
    if (COMMIT && PC_LD) begin
      pc_next = PC_D;
    end
  end

  // State, PC and IR registers with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= IDLE;
      pc       <= RESET_VECTOR;
      ir       <= 16'h0000;
      ir_valid <= 1'b0;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      ir       <= ir_next;
      ir_valid <= ir_valid_next;
    end
  end

  // RD_EN follows FETCH in both states. The abort cycle releases the sequencer.
  assign ADDR        = pc;
  assign PC          = pc;
  assign RD_EN       = FETCH;
  assign STALL       = FETCH & RD_EN & !MEM_READY & !timeout_hit;
  assign INSTRUCTION = ir;
  assign IR_VALID    = ir_valid;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed testbench for instruction_fetch_unit. It covers reset, zero-wait
// fetch, wait states, branch load, PC wrap, mid-wait reset and illegal FETCH
// drop. It also covers the timeout abort (FETCH_TIMEOUT_EN) or unbounded wait.
module tb_instruction_fetch_unit;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        FETCH, DECODE, EXECUTE, COMMIT;
  logic [15:0] DATA_IN;
  logic        MEM_READY;
  logic        PC_LD;
  logic [15:0] PC_D;
  logic [15:0] ADDR;
  logic        RD_EN;
  logic        STALL;
  logic [15:0] INSTRUCTION;
  logic        IR_VALID;
  logic [15:0] PC;
  logic        FETCH_FAULT;

  int compared   = 0;
  int mismatched = 0;

  instruction_fetch_unit dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .FETCH       (FETCH),
    .DECODE      (DECODE),
    .EXECUTE     (EXECUTE),
    .COMMIT      (COMMIT),
    .DATA_IN     (DATA_IN),
    .MEM_READY   (MEM_READY),
    .PC_LD       (PC_LD),
    .PC_D        (PC_D),
    .ADDR        (ADDR),
    .RD_EN       (RD_EN),
    .STALL       (STALL),
    .INSTRUCTION (INSTRUCTION),
    .IR_VALID    (IR_VALID),
    .PC          (PC),
    .FETCH_FAULT (FETCH_FAULT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic phase(input logic f, input logic d, input logic e, input logic c);
    FETCH   = f;
    DECODE  = d;
    EXECUTE = e;
    COMMIT  = c;
  endtask

  // Inputs change just after a falling edge. The next falling edge is half a
  // cycle after the rising edge that consumes them.
  task automatic next_cycle();
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    phase(1'b0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    RESET = 1'b0;
  endtask

  // A COMMIT-only cycle with an optional branch load.
  task automatic commit_cycle(input logic ld, input logic [15:0] target);
    phase(1'b0, 1'b0, 1'b0, 1'b1);
    PC_LD = ld;
    PC_D  = target;
    next_cycle();
    PC_LD = 1'b0;
    phase(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    RESET = 1'b1; MEM_READY = 1'b0; DATA_IN = 16'h0000; PC_LD = 1'b0; PC_D = 16'h0000;
    phase(1'b0, 1'b0, 1'b0, 1'b0);

    // Reset held for two cycles.
    next_cycle();
    next_cycle();
    check("rst_pc",       PC,          16'h0000);
    check("rst_addr",     ADDR,        16'h0000);
    check("rst_instr",    INSTRUCTION, 16'h0000);
    check("rst_ir_valid", IR_VALID,    16'd0);
    check("rst_rd_en",    RD_EN,       16'd0);
    check("rst_stall",    STALL,       16'd0);
    check("rst_fault",    FETCH_FAULT, 16'd0);
    RESET = 1'b0;

    // Zero-wait fetch of 1234.
    phase(1'b1, 1'b0, 1'b0, 1'b0); MEM_READY = 1'b1; DATA_IN = 16'h1234;
    #1;
    check("zw_rd_en", RD_EN, 16'd1);
    check("zw_stall", STALL, 16'd0);
    check("zw_addr",  ADDR,  16'h0000);
    next_cycle();
    phase(1'b0, 1'b1, 1'b0, 1'b0); MEM_READY = 1'b0;
    #1;
    check("zw_instr",    INSTRUCTION, 16'h1234);
    check("zw_ir_valid", IR_VALID,    16'd1);
    check("zw_pc",       PC,          16'h0002);
    check("zw_rd_en_dec", RD_EN,      16'd0);
    next_cycle();
    phase(1'b0, 1'b0, 1'b1, 1'b0);
    next_cycle();
    check("zw_valid_exec", IR_VALID, 16'd1);
    commit_cycle(1'b0, 16'h0000);
    check("zw_valid_after_commit", IR_VALID,    16'd0);
    check("zw_instr_after_commit", INSTRUCTION, 16'h1234);

    // Three wait states, then A5A5 from a fresh reset.
    do_reset();
    phase(1'b1, 1'b0, 1'b0, 1'b0); MEM_READY = 1'b0; DATA_IN = 16'hA5A5;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("ws_stall_%0d", i), STALL, 16'd1);
      next_cycle();
      check($sformatf("ws_instr_hold_%0d", i), INSTRUCTION, 16'h0000);
      check($sformatf("ws_pc_hold_%0d", i),    PC,          16'h0000);
    end
    MEM_READY = 1'b1;
    #1;
    check("ws_stall_release", STALL, 16'd0);
    next_cycle();
    check("ws_instr",    INSTRUCTION, 16'hA5A5);
    check("ws_ir_valid", IR_VALID,    16'd1);
    check("ws_pc",       PC,          16'h0002);

    // PC_LD outside COMMIT is ignored. A branch in COMMIT lands on the next ADDR.
    phase(1'b0, 1'b1, 1'b0, 1'b0); MEM_READY = 1'b0;
    next_cycle();
    phase(1'b0, 1'b0, 1'b1, 1'b0); PC_LD = 1'b1; PC_D = 16'h0BAD;
    next_cycle();
    PC_LD = 1'b0;
    check("br_exec_ignored", PC, 16'h0002);
    commit_cycle(1'b1, 16'h0100);
    check("br_pc", PC, 16'h0100);
    phase(1'b1, 1'b0, 1'b0, 1'b0); MEM_READY = 1'b1; DATA_IN = 16'h4321;
    #1;
    check("br_next_addr", ADDR, 16'h0100);
    next_cycle();
    check("br_fetch_instr", INSTRUCTION, 16'h4321);
    check("br_fetch_pc",    PC,          16'h0102);

    // PC wraps from FFFE to 0000.
    commit_cycle(1'b1, 16'hFFFE);
    check("wrap_pre", PC, 16'hFFFE);
    phase(1'b1, 1'b0, 1'b0, 1'b0); MEM_READY = 1'b1; DATA_IN = 16'hBEEF;
    next_cycle();
    check("wrap_pc",    PC,          16'h0000);
    check("wrap_instr", INSTRUCTION, 16'hBEEF);

    // FETCH dropped mid-wait: no latch and no PC change, even with MEM_READY high.
    commit_cycle(1'b0, 16'h0000);
    phase(1'b1, 1'b0, 1'b0, 1'b0); MEM_READY = 1'b0; DATA_IN = 16'hDEAD;
    next_cycle();
    phase(1'b0, 1'b0, 1'b0, 1'b0); MEM_READY = 1'b1;
    #1;
    check("drop_rd_en", RD_EN, 16'd0);
    check("drop_stall", STALL, 16'd0);
    next_cycle();
    check("drop_instr", INSTRUCTION, 16'hBEEF);
    check("drop_pc",    PC,          16'h0000);
    check("drop_valid", IR_VALID,    16'd0);

    // Reset asserted in the middle of a wait.
    commit_cycle(1'b1, 16'h0200);
    phase(1'b1, 1'b0, 1'b0, 1'b0); MEM_READY = 1'b0; DATA_IN = 16'h9999;
    next_cycle();
    next_cycle();
    RESET = 1'b1;
    next_cycle();
    RESET = 1'b0; phase(1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check("mrst_pc",    PC,          16'h0000);
    check("mrst_stall", STALL,       16'd0);
    check("mrst_instr", INSTRUCTION, 16'h0000);
    check("mrst_valid", IR_VALID,    16'd0);
    next_cycle();
    phase(1'b1, 1'b0, 1'b0, 1'b0); MEM_READY = 1'b1; DATA_IN = 16'h7777;
    #1;
    check("mrst_fetch_stall", STALL, 16'd0);
    next_cycle();
    check("mrst_fetch_instr", INSTRUCTION, 16'h7777);
    check("mrst_fetch_pc",    PC,          16'h0002);

`ifdef FETCH_TIMEOUT_EN
    // Memory never answers. The first FETCH cycle plus 14 WAIT cycles stall.
    // The 15th WAIT cycle (counter = 15) releases STALL and injects a NOP.
    phase(1'b1, 1'b0, 1'b0, 1'b0); MEM_READY = 1'b0; DATA_IN = 16'hCCCC;
    for (int i = 0; i < 15; i++) begin
      #1;
      check($sformatf("to_stall_%0d", i), STALL, 16'd1);
      next_cycle();
    end
    #1;
    check("to_stall_drop", STALL, 16'd0);
    next_cycle();
    phase(1'b0, 1'b0, 1'b0, 1'b0);
    check("to_instr", INSTRUCTION, 16'h0000);
    check("to_valid", IR_VALID,    16'd1);
    check("to_fault", FETCH_FAULT, 16'd1);
    check("to_pc",    PC,          16'h0002);
    phase(1'b1, 1'b0, 1'b0, 1'b0); MEM_READY = 1'b1; DATA_IN = 16'h2468;
    next_cycle();
    check("to_refetch_instr", INSTRUCTION, 16'h2468);
    check("to_refetch_pc",    PC,          16'h0004);
    check("to_fault_sticky",  FETCH_FAULT, 16'd1);
    do_reset();
    check("to_fault_cleared", FETCH_FAULT, 16'd0);
`else
    // With no timeout logic a long wait just keeps stalling.
    phase(1'b1, 1'b0, 1'b0, 1'b0); MEM_READY = 1'b0; DATA_IN = 16'hCCCC;
    for (int i = 0; i < 20; i++) begin
      #1;
      check($sformatf("lw_stall_%0d", i), STALL, 16'd1);
      next_cycle();
    end
    check("lw_instr_hold", INSTRUCTION, 16'h7777);
    MEM_READY = 1'b1; DATA_IN = 16'h2468;
    next_cycle();
    check("lw_instr", INSTRUCTION, 16'h2468);
    check("lw_pc",    PC,          16'h0004);
    check("lw_fault", FETCH_FAULT, 16'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
